// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: instruction memory with a byte-stream program loader.
//   In RUN, rd_addr is fetched with one cycle of latency; words that have not
//   been written since the last load started read back as zero (NOP).
//   In LOAD, a valid/ready byte stream is assembled MSB-first into DATA_W-bit
//   words, which are written to consecutive addresses starting at 0.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   rd_addr     - fetch address (taken modulo depth)
//   rd_data     - registered fetched instruction
//   mem_ready   - high in RUN (fetches valid)
//   ld_start    - pulse in RUN to begin a load
//   ld_valid    - loader byte valid
//   ld_ready    - loader byte accepted (high in LOAD)
//   ld_byte     - loader byte
//   ld_last     - marks the final byte of the program
//   ld_words    - words written by the current/last load
//   ld_err      - sticky error of the last load (partial word or overflow)
module prog_mem_loadable #(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_ready,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic [ADDR_W:0]   ld_words,
  output logic              ld_err
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BIDX_W-1:0] LAST_IDX   = BIDX_W'(NBYTES - 1);
  localparam logic [BIDX_W-1:0] IDX_ONE    = BIDX_W'(1);
  localparam logic [ADDR_W:0]   WORDS_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   WORDS_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    ST_RUN,
    ST_LOAD
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [BIDX_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_en;
  logic              accept;
  logic              load_end;

  assign accept   = (state_q == ST_LOAD) && ld_valid;
  assign load_end = accept && ld_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (ld_start) state_d = ST_LOAD;
      ST_LOAD: if (load_end) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    ld_ready  = 1'b0;
    mem_ready = 1'b0;
    unique case (state_q)
      ST_RUN:  mem_ready = 1'b1;
      ST_LOAD: ld_ready  = 1'b1;
      default: mem_ready = 1'b1;
    endcase
  end

  // Loader datapath
  always_comb begin
    vld_d   = vld_q;
    words_d = words_q;
    idx_d   = idx_q;
    err_d   = err_q;
    asm_d   = asm_q;
    wr_en   = 1'b0;
    if ((state_q == ST_RUN) && ld_start) begin
      vld_d   = '0;
      words_d = '0;
      idx_d   = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (words_q == WORDS_FULL) begin
        // Array full: the byte is dropped and the load is flagged.
        err_d = 1'b1;
      end else begin
        // Shifting bytes in from the bottom and keeping DATA_W bits leaves
        // only the low bits of the first byte once the word is complete.
        asm_d = DATA_W'({asm_q, ld_byte});
        if (idx_q == LAST_IDX) begin
          wr_en                        = 1'b1;
          vld_d[words_q[ADDR_W-1:0]]   = 1'b1;
          words_d                      = words_q + WORDS_ONE;
          idx_d                        = '0;
        end else if (ld_last) begin
          err_d = 1'b1;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      words_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
    end
  end

  // Array storage is not reset; the valid bits make stale contents unreadable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[words_q[ADDR_W-1:0]] <= asm_d;
    end
  end

  // Registered fetch; reads the pre-write contents on a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if ((state_q == ST_RUN) && vld_q[rd_addr]) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign ld_words = words_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
module tb_prog_mem_loadable;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic [34:0] rd_data;
  logic        mem_ready;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic [8:0]  ld_words;
  logic        ld_err;

  int unsigned total;
  int unsigned bad;

  prog_mem_loadable #(.DATA_W(35), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .mem_ready (mem_ready),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_words  (ld_words),
    .ld_err    (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [34:0] exp;
  } fvec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driving and sampling happens just after the falling edge.
  task automatic fetch(input string name, input logic [7:0] a, input logic [34:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(name, {29'd0, rd_data}, {29'd0, exp});
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  fvec_t fv[6];
  logic [7:0] b33[10];
  logic [7:0] k8;

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = '0;
    ld_last  = 1'b0;

    b33 = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fv[0] = '{8'd0,   35'h5_0102_0304};
    fv[1] = '{8'd1,   35'h7_AABB_CCDD};
    fv[2] = '{8'd2,   35'h0};
    fv[3] = '{8'd255, 35'h0};
    fv[4] = '{8'd0,   35'h5_0102_0304};
    fv[5] = '{8'd3,   35'h0};

    // Reset state
    #1;
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("rst_ld_ready",  {63'd0, ld_ready},  64'd0);
    chk("rst_ld_words",  {55'd0, ld_words},  64'd0);
    chk("rst_ld_err",    {63'd0, ld_err},    64'd0);
    chk("rst_rd_data",   {29'd0, rd_data},   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch("empty_fetch0", 8'd0, 35'h0);
    fetch("empty_fetch255", 8'd255, 35'h0);
    chk("empty_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("empty_ld_words", {55'd0, ld_words}, 64'd0);

    // Two-word load with a valid gap and a fetch during LOAD
    start_load();
    chk("load_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("load_mem_ready", {63'd0, mem_ready}, 64'd0);
    for (int unsigned i = 0; i < 5; i++) send_byte(b33[i], 1'b0);
    chk("load_words_after1", {55'd0, ld_words}, 64'd1);
    rd_addr = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("load_fetch_nop", {29'd0, rd_data}, 64'd0);
    chk("gap_no_write", {55'd0, ld_words}, 64'd1);
    ld_start = 1'b1;      // ignored while loading
    @(negedge clk);
    ld_start = 1'b0;
    chk("start_in_load_ignored", {55'd0, ld_words}, 64'd1);
    for (int unsigned i = 5; i < 10; i++) send_byte(b33[i], i == 9);
    chk("two_words_run", {63'd0, mem_ready}, 64'd1);
    chk("two_words_count", {55'd0, ld_words}, 64'd2);
    chk("two_words_err", {63'd0, ld_err}, 64'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      fetch($sformatf("tbl_fetch%0d_a%0d", i, fv[i].addr), fv[i].addr, fv[i].exp);
    end

    // Partial trailing word
    start_load();
    for (int unsigned i = 1; i <= 7; i++) send_byte(8'(i), i == 7);
    chk("partial_words", {55'd0, ld_words}, 64'd1);
    chk("partial_err", {63'd0, ld_err}, 64'd1);
    chk("partial_run", {63'd0, mem_ready}, 64'd1);
    chk("partial_ld_ready", {63'd0, ld_ready}, 64'd0);
    fetch("partial_fetch0", 8'd0, 35'h1_0203_0405);
    fetch("partial_fetch1", 8'd1, 35'h0);

    // Overflow: 257 words into a 256-word array
    start_load();
    for (int unsigned k = 0; k < 257; k++) begin
      k8 = 8'(k);
      send_byte(8'(k >> 8), 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(k8, 1'b0);
      send_byte(8'h5A, 1'b0);
      send_byte(k8, k == 256);
    end
    chk("ovf_words", {55'd0, ld_words}, 64'd256);
    chk("ovf_err", {63'd0, ld_err}, 64'd1);
    chk("ovf_run", {63'd0, mem_ready}, 64'd1);
    fetch("ovf_fetch0", 8'd0, 35'h0_A500_5A00);
    fetch("ovf_fetch7", 8'd7, 35'h0_A507_5A07);
    fetch("ovf_fetch255", 8'd255, 35'h0_A5FF_5AFF);

    // Reset in the middle of a load
    start_load();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("abort_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("abort_ld_words", {55'd0, ld_words}, 64'd0);
    chk("abort_rd_data", {29'd0, rd_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch("abort_fetch0", 8'd0, 35'h0);
    fetch("abort_fetch255", 8'd255, 35'h0);
    start_load();
    send_byte(8'h06, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    chk("reload_words", {55'd0, ld_words}, 64'd1);
    chk("reload_err", {63'd0, ld_err}, 64'd0);
    fetch("reload_fetch0", 8'd0, 35'h6_1122_3344);
    fetch("reload_fetch1", 8'd1, 35'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
